disparity_wta: RTL

- Winner-take-all selector directly downstream of calculate_ssd_block.
- Consumes one SSD per candidate disparity for the current left block. Tracks the minimum and the second-best SSD, then emits the winning disparity, its SSD and a uniqueness flag.
- Output feeds the disparity-map writer.
- One block per start; candidates arrive in disparity order 0,1,2,...

---
 rtl/stereo_pkg.sv | 22 ++
 rtl/min2_tracker.sv | 52 +++++
 rtl/disparity_wta.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/stereo_pkg.sv
// rtl/stereo_pkg.sv - shared stereo-pipeline constants and WTA state type
// Purpose : image/block geometry derived widths shared by the stereo blocks,
//           and the state type used by the disparity winner-take-all FSM.
// Ports   : none (package).
package stereo_pkg;

   localparam int IMG_W = 240;
   localparam int IMG_H = 320;
   localparam int BLK   = 6;

   localparam int X_W   = $clog2(IMG_W) + 1;
   localparam int Y_W   = $clog2(IMG_H) + 1;
   // Worst-case SSD of a BLKxBLK window of 8-bit pixels, plus one bit of headroom.
   localparam int SSD_W = $clog2(255 * 255 * BLK * BLK) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      EMIT  = 2'd2
   } wta_state_t;

endpackage

// File: rtl/min2_tracker.sv
// rtl/min2_tracker.sv - running minimum and runner-up tracker
// Purpose : keeps the smallest value seen, its index and the second smallest
//           value (duplicates count, so two equal minima make second == best).
// Ports   : clk_in, rst_in (async, active-high), clear_in (restart tracking),
//           valid_in / value_in / index_in (sample), best_out, best_idx_out,
//           second_out.
module min2_tracker #(
   parameter int VAL_W = 23,
   parameter int IDX_W = 4
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             clear_in,
   input  logic             valid_in,
   input  logic [VAL_W-1:0] value_in,
   input  logic [IDX_W-1:0] index_in,
   output logic [VAL_W-1:0] best_out,
   output logic [IDX_W-1:0] best_idx_out,
   output logic [VAL_W-1:0] second_out
);

   logic [VAL_W-1:0] r_best;
   logic [VAL_W-1:0] r_second;
   logic [IDX_W-1:0] r_best_idx;

   // Strict compares: an equal later value never displaces the earlier
   // (lower-index) winner, but it does become the runner-up.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_best     <= '1;
         r_second   <= '1;
         r_best_idx <= '0;
      end else if (clear_in) begin
         r_best     <= '1;
         r_second   <= '1;
         r_best_idx <= '0;
      end else if (valid_in) begin
         if (value_in < r_best) begin
            r_second   <= r_best;
            r_best     <= value_in;
            r_best_idx <= index_in;
         end else if (value_in < r_second) begin
            r_second <= value_in;
         end
      end
   end

   assign best_out     = r_best;
   assign best_idx_out = r_best_idx;
   assign second_out   = r_second;

endmodule

// File: rtl/disparity_wta.sv
// rtl/disparity_wta.sv - winner-take-all disparity selector
// Purpose : consumes one SSD per candidate disparity of a block, picks the
//           lowest SSD (lowest disparity on ties) and flags whether it beats
//           the runner-up by a margin of best >> UNIQ_SHIFT.
// Ports   : clk_in, rst_in (async, active-high); start_in with num_cand_in,
//           block_x_in, block_y_in; ssd_valid_in / ssd_in candidate stream;
//           busy_out; disp_valid_out strobe with disp_out, min_ssd_out,
//           confident_out, block_x_out, block_y_out; sticky overrun_out.
module disparity_wta #(
   parameter int MAX_DISP   = 16,
   parameter int SSD_W      = 23,
   parameter int UNIQ_SHIFT = 3
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic                         start_in,
   input  logic [$clog2(MAX_DISP):0]    num_cand_in,
   input  logic [stereo_pkg::X_W-1:0]   block_x_in,
   input  logic [stereo_pkg::Y_W-1:0]   block_y_in,
   input  logic                         ssd_valid_in,
   input  logic [SSD_W-1:0]             ssd_in,
   output logic                         busy_out,
   output logic                         disp_valid_out,
   output logic [$clog2(MAX_DISP)-1:0]  disp_out,
   output logic [SSD_W-1:0]             min_ssd_out,
   output logic                         confident_out,
   output logic [stereo_pkg::X_W-1:0]   block_x_out,
   output logic [stereo_pkg::Y_W-1:0]   block_y_out,
   output logic                         overrun_out
);

   import stereo_pkg::*;

   localparam int                DISP_W  = $clog2(MAX_DISP);
   localparam int                CNT_W   = DISP_W + 1;
   localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_DISP);

   wta_state_t        r_state;
   wta_state_t        w_next_state;

   logic [CNT_W-1:0]  r_num_cand;
   logic [DISP_W-1:0] r_cnt;
   logic [X_W-1:0]    r_x;
   logic [Y_W-1:0]    r_y;

   logic [DISP_W-1:0] r_disp_hold;
   logic [SSD_W-1:0]  r_min_hold;
   logic              r_conf_hold;
   logic [X_W-1:0]    r_x_hold;
   logic [Y_W-1:0]    r_y_hold;
   logic              r_overrun;

   logic [CNT_W-1:0]  w_num_clamped;
   logic              w_clear;
   logic              w_acc_valid;
   logic              w_last;
   logic              w_disp_valid;
   logic [SSD_W-1:0]  w_best;
   logic [SSD_W-1:0]  w_second;
   logic [DISP_W-1:0] w_best_idx;
   logic [SSD_W:0]    w_sum;
   logic              w_confident;

   assign w_num_clamped = (num_cand_in > MAX_CNT) ? MAX_CNT : num_cand_in;
   assign w_clear       = (r_state == IDLE) && start_in;
   assign w_acc_valid   = (r_state == ACCUM) && ssd_valid_in;
   // r_num_cand is never zero while in ACCUM, so the subtraction cannot wrap.
   assign w_last        = w_acc_valid && ({1'b0, r_cnt} == (r_num_cand - CNT_W'(1)));

   min2_tracker #(
      .VAL_W (SSD_W),
      .IDX_W (DISP_W)
   ) u_min2 (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .clear_in     (w_clear),
      .valid_in     (w_acc_valid),
      .value_in     (ssd_in),
      .index_in     (r_cnt),
      .best_out     (w_best),
      .best_idx_out (w_best_idx),
      .second_out   (w_second)
   );

   // One extra bit so best + best/2^k cannot wrap; an all-ones best with no
   // runner-up therefore never reads as confident.
   assign w_sum       = {1'b0, w_best} + {1'b0, (w_best >> UNIQ_SHIFT)};
   assign w_confident = (w_sum < {1'b0, w_second});

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_disp_valid = 1'b0;
      case (r_state)
         IDLE: begin
            if (start_in) begin
               w_next_state = (w_num_clamped == '0) ? EMIT : ACCUM;
            end
         end
         ACCUM: begin
            if (w_last) begin
               w_next_state = EMIT;
            end
         end
         EMIT: begin
            w_disp_valid = 1'b1;
            w_next_state = IDLE;
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_num_cand <= '0;
         r_cnt      <= '0;
         r_x        <= '0;
         r_y        <= '0;
      end else if (w_clear) begin
         r_num_cand <= w_num_clamped;
         r_cnt      <= '0;
         r_x        <= block_x_in;
         r_y        <= block_y_in;
      end else if (w_acc_valid) begin
         r_cnt <= r_cnt + DISP_W'(1);
      end
   end

   // Result registers capture during EMIT so the outputs hold between strobes.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_disp_hold <= '0;
         r_min_hold  <= '0;
         r_conf_hold <= 1'b0;
         r_x_hold    <= '0;
         r_y_hold    <= '0;
      end else if (w_disp_valid) begin
         r_disp_hold <= w_best_idx;
         r_min_hold  <= w_best;
         r_conf_hold <= w_confident;
         r_x_hold    <= r_x;
         r_y_hold    <= r_y;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_overrun <= 1'b0;
      end else if ((start_in && (r_state != IDLE)) ||
                   (ssd_valid_in && (r_state == EMIT))) begin
         r_overrun <= 1'b1;
      end
   end

   // During EMIT the live tracker values are shown so the strobe needs no
   // extra pipeline stage after the final candidate.
   assign busy_out       = (r_state != IDLE);
   assign disp_valid_out = w_disp_valid;
   assign disp_out       = w_disp_valid ? w_best_idx  : r_disp_hold;
   assign min_ssd_out    = w_disp_valid ? w_best      : r_min_hold;
   assign confident_out  = w_disp_valid ? w_confident : r_conf_hold;
   assign block_x_out    = w_disp_valid ? r_x         : r_x_hold;
   assign block_y_out    = w_disp_valid ? r_y         : r_y_hold;
   assign overrun_out    = r_overrun;

endmodule
